// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store data port and the
// memory command/response bus seen by mem_arbiter.
// slave  - the arbiter's view (requests in, grants/read data/memory command out)
// master - the view of whatever drives the requests and models the memory
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    // Load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    // Single-port synchronous memory
    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the core's
// instruction-fetch port and its load/store data port. One request is accepted
// per grant and the memory command is driven combinationally in the grant cycle.
// Reads return to their owner RD_LATENCY cycles later; stores finish at grant.
// Optional feature macro ARB_RR_EN: when defined, simultaneous requests are
// resolved round-robin; when undefined, the data port has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    // lat_cnt is two bits, so a latency of 4 is reached when it wraps to 0
    localparam logic [1:0] LAT_FINAL = 2'(RD_LATENCY);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic              owner_q, owner_d;
`ifdef ARB_RR_EN
    logic              last_gnt_q, last_gnt_d;
`endif

    logic              rd_done;
    logic              rd_valid;
    logic              gnt_allowed;
    logic              pick_data;
    logic              grant_data;
    logic              grant_fetch;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [BE_W-1:0]   be_mux;

    // State registers; reset drops any read still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_cnt_q  <= 2'd0;
            owner_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            owner_q    <= owner_d;
`ifdef ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // Grant decision: a new grant may issue when idle or in the read-return cycle
    always_comb begin
        rd_done     = (state_q == RD_WAIT) && (lat_cnt_q == LAT_FINAL);
        rd_valid    = rd_done && !reset;
        gnt_allowed = !reset && ((state_q == IDLE) || rd_done);
`ifdef ARB_RR_EN
        pick_data   = bus.d_req && (!bus.if_req || !last_gnt_q);
`else
        pick_data   = bus.d_req;
`endif
        grant_data  = gnt_allowed && pick_data;
        grant_fetch = gnt_allowed && bus.if_req && !pick_data;
    end

    // Memory command mux; everything is zero when nothing is granted
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        be_mux    = '0;
        if (grant_data) begin
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
            be_mux    = bus.d_we ? bus.d_be : '1;
        end else if (grant_fetch) begin
            addr_mux  = bus.if_addr;
            be_mux    = '1;
        end
        bus.mem_en    = grant_data || grant_fetch;
        bus.mem_we    = grant_data && bus.d_we;
        bus.mem_be    = be_mux;
        bus.mem_addr  = addr_mux;
        bus.mem_wdata = wdata_mux;
        bus.if_gnt    = grant_fetch;
        bus.d_gnt     = grant_data;
    end

    // Read return: route memory data to the owner only in its rvalid cycle
    always_comb begin
        bus.if_rvalid = rd_valid && !owner_q;
        bus.d_rvalid  = rd_valid && owner_q;
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
    end

    // Next-state: count out the read latency, then accept the next grant or go idle
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
`ifdef ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        if (state_q == RD_WAIT) begin
            if (rd_done) begin
                state_d   = IDLE;
                lat_cnt_d = 2'd0;
            end else begin
                lat_cnt_d = lat_cnt_q + 2'd1;
            end
        end
        if (grant_data || grant_fetch) begin
            if (grant_data && bus.d_we) begin
                state_d   = IDLE;
                lat_cnt_d = 2'd0;
            end else begin
                state_d   = RD_WAIT;
                lat_cnt_d = 2'd1;
                owner_d   = grant_data;
            end
`ifdef ARB_RR_EN
            last_gnt_d = grant_data;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. One instance runs with
// RD_LATENCY=1 under a read scoreboard; a second runs with RD_LATENCY=3 to
// exercise a reset that lands in the middle of a pending read.
// Honours ARB_RR_EN in its expected arbitration when the macro is defined.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;
    logic last_gnt_data = 1'b1;
    logic exp_fetch_last;
    logic exp_data_last;
    logic pend_if;
    logic pend_d;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        if_q[$];
    exp_t        d_q[$];
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_arr [logic [31:0]];
    logic [31:0] pipe1 = 32'h0;
    logic [31:0] pipe3 [3];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Initial memory image: a known instruction at 0x4, an address pattern elsewhere
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] w;
        w = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
        return w;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_arr.exists(a) ? ref_arr[a] : init_word(a);
    endfunction

    // Memory behind dut1: stores land at the grant edge
    always @(posedge clk) begin
        if (bus1.mem_en && bus1.mem_we)
            mem_arr[bus1.mem_addr] = merge_be(mem_rd(bus1.mem_addr), bus1.mem_wdata, bus1.mem_be);
    end

    // Memory behind dut1: one-cycle read pipeline, junk when no read was issued
    always @(posedge clk) begin
        pipe1 <= (bus1.mem_en && !bus1.mem_we) ? mem_rd(bus1.mem_addr) : 32'hBAD1_BAD1;
    end
    assign bus1.mem_rdata = pipe1;

    // Memory behind dut3: read-only, three-cycle read pipeline
    always @(posedge clk) begin
        pipe3[0] <= (bus3.mem_en && !bus3.mem_we) ? init_word(bus3.mem_addr) : 32'hBAD3_BAD3;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus3.mem_rdata = pipe3[2];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic expectQuiet1(input string tag);
        checkOutput({tag, "_ctl"}, 32'({bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid, bus1.d_rvalid,
                                        bus1.mem_en, bus1.mem_we, bus1.mem_be}), 32'h0);
        checkOutput({tag, "_addr"}, bus1.mem_addr, 32'h0);
        checkOutput({tag, "_wdata"}, bus1.mem_wdata, 32'h0);
        checkOutput({tag, "_rdata"}, bus1.if_rdata | bus1.d_rdata, 32'h0);
    endtask

    task automatic expectQuiet3(input string tag);
        checkOutput({tag, "_ctl"}, 32'({bus3.if_gnt, bus3.d_gnt, bus3.if_rvalid, bus3.d_rvalid,
                                        bus3.mem_en, bus3.mem_we, bus3.mem_be}), 32'h0);
        checkOutput({tag, "_addr"}, bus3.mem_addr, 32'h0);
        checkOutput({tag, "_rdata"}, bus3.if_rdata | bus3.d_rdata, 32'h0);
    endtask

    // One dut1 cycle: drive requests, check grant and memory command, queue expected reads
    task automatic applyStimulus(input logic        if_req,
                                 input logic [31:0] if_addr,
                                 input logic        d_req,
                                 input logic        d_we,
                                 input logic [3:0]  d_be,
                                 input logic [31:0] d_addr,
                                 input logic [31:0] d_wdata);
        logic exp_d;
        logic exp_f;
        bus1.if_req  = if_req;
        bus1.if_addr = if_addr;
        bus1.d_req   = d_req;
        bus1.d_we    = d_we;
        bus1.d_be    = d_be;
        bus1.d_addr  = d_addr;
        bus1.d_wdata = d_wdata;
`ifdef ARB_RR_EN
        exp_d = d_req && (!if_req || !last_gnt_data);
`else
        exp_d = d_req;
`endif
        exp_f = if_req && !exp_d;
        @(negedge clk);
        checkOutput("if_gnt", bus1.if_gnt, exp_f);
        checkOutput("d_gnt", bus1.d_gnt, exp_d);
        checkOutput("mem_en", bus1.mem_en, exp_d | exp_f);
        checkOutput("mem_we", bus1.mem_we, exp_d & d_we);
        checkOutput("mem_be", bus1.mem_be, exp_d ? (d_we ? d_be : 4'hF) : (exp_f ? 4'hF : 4'h0));
        checkOutput("mem_addr", bus1.mem_addr, exp_d ? d_addr : (exp_f ? if_addr : 32'h0));
        checkOutput("mem_wdata", bus1.mem_wdata, exp_d ? d_wdata : 32'h0);
        if (exp_f) if_q.push_back('{data: ref_rd(if_addr), due: cyc + 1});
        if (exp_d && !d_we) d_q.push_back('{data: ref_rd(d_addr), due: cyc + 1});
        if (exp_d && d_we) ref_arr[d_addr] = merge_be(ref_rd(d_addr), d_wdata, d_be);
        if (exp_d || exp_f) last_gnt_data = exp_d;
        exp_data_last  = exp_d;
        exp_fetch_last = exp_f;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for dut1: each rvalid must land on the cycle its entry is due
    always @(negedge clk) begin
        if (mon_on) begin
            logic exp_v;
            exp_v = (if_q.size() > 0) && (if_q[0].due == cyc);
            checkOutput("if_rvalid", bus1.if_rvalid, exp_v);
            checkOutput("if_rdata", bus1.if_rdata, exp_v ? if_q[0].data : 32'h0);
            if (exp_v) void'(if_q.pop_front());
            exp_v = (d_q.size() > 0) && (d_q[0].due == cyc);
            checkOutput("d_rvalid", bus1.d_rvalid, exp_v);
            checkOutput("d_rdata", bus1.d_rdata, exp_v ? d_q[0].data : 32'h0);
            if (exp_v) void'(d_q.pop_front());
        end
    end

    initial begin
        rst1 = 1'b1;
        rst3 = 1'b1;
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        bus3.d_be = '0; bus3.d_addr = '0; bus3.d_wdata = '0;
        // Requests held active during reset must not leak through
        bus1.if_req = 1'b1; bus1.if_addr = 32'h10; bus1.d_req = 1'b1; bus1.d_we = 1'b1;
        bus1.d_be = 4'hF; bus1.d_addr = 32'h20; bus1.d_wdata = 32'h1234_5678;
        repeat (2) begin
            @(negedge clk);
            expectQuiet1("rst1");
        end
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        bus1.if_req = 1'b0; bus1.d_req = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        expectQuiet1("idle1");
        @(posedge clk);
        #1;

        // Lone fetch of the instruction at 0x4
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Half-word store, then a load of the same word sees the merge
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'b1010, 32'h100, 32'h5555_AAAA);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Fetch and load together; each holds its request until granted
        pend_if = 1'b1;
        pend_d  = 1'b1;
        for (int k = 0; k < 4 && (pend_if || pend_d); k++) begin
            applyStimulus(pend_if, 32'h8, pend_d, 1'b0, 4'h0, 32'h200, 32'h0);
            if (exp_fetch_last) pend_if = 1'b0;
            if (exp_data_last) pend_d = 1'b0;
        end
        checkOutput("both_served", 32'({pend_if, pend_d}), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // A lone fetch, then six cycles of both ports requesting
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, 32'h40 + 32'(4 * k), 1'b1, 1'b0, 4'h0, 32'h80 + 32'(4 * k), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Back-to-back fetches give consecutive rvalid pulses
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Random mix of fetches, loads and stores over an overlapping window
        for (int k = 0; k < 40; k++)
            applyStimulus(1'($urandom_range(0, 1)), 32'hF0 + 32'(4 * $urandom_range(0, 11)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          32'hF0 + 32'(4 * $urandom_range(0, 11)), $urandom);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("if_q_drained", 32'(if_q.size()), 32'h0);
        checkOutput("d_q_drained", 32'(d_q.size()), 32'h0);
        mon_on = 1'b0;

        // RD_LATENCY=3: load granted, reset lands on the second wait cycle
        rst3 = 1'b0;
        @(negedge clk);
        expectQuiet3("idle3");
        @(posedge clk);
        #1;
        bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_be = 4'h0; bus3.d_addr = 32'h40;
        @(negedge clk);
        checkOutput("d3_gnt", bus3.d_gnt, 1'b1);
        checkOutput("d3_mem_addr", bus3.mem_addr, 32'h40);
        checkOutput("d3_mem_be", bus3.mem_be, 4'hF);
        @(posedge clk);
        #1;
        bus3.d_req = 1'b0;
        @(negedge clk);
        checkOutput("d3_wait1_rvalid", bus3.d_rvalid, 1'b0);
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        bus3.if_req = 1'b1; bus3.if_addr = 32'h44;
        repeat (2) begin
            @(negedge clk);
            expectQuiet3("rst3");
            @(posedge clk);
            #1;
        end
        rst3 = 1'b0;
        bus3.if_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            expectQuiet3("post_rst3");
            @(posedge clk);
            #1;
        end

        // Arbiter is idle again: a fetch returns exactly three cycles after grant
        bus3.if_req = 1'b1;
        @(negedge clk);
        checkOutput("d3_if_gnt", bus3.if_gnt, 1'b1);
        checkOutput("d3_if_mem_addr", bus3.mem_addr, 32'h44);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            bus3.if_req = 1'b0;
            @(negedge clk);
            checkOutput("d3_if_rvalid", bus3.if_rvalid, k == 3);
            checkOutput("d3_if_rdata", bus3.if_rdata, (k == 3) ? init_word(32'h44) : 32'h0);
            checkOutput("d3_d_rvalid", bus3.d_rvalid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
